arm_mainfsm: RTL and testbench
==============================

Name: arm_mainfsm

Overview:
- Main control FSM for the multicycle ARM datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the write enables and mux selects of the datapath's state registers: PC, instruction register, data register and ALU-out.
- Its raw regw/memw/branch strobes are consumed by the downstream condition-check logic, which gates them with the condition flags.
- Adds a memory-ready handshake so that fetch and memory states stall on slow memory.

Parameters:
- STATE_W, 4, state register width; must be at least 4 to encode the 12 states.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op  in  2  instr[27:26] from the instruction register
- funct  in  6  instr[25:20]; bit5 = I (immediate), bit0 = L/S
- mem_ready  in  1  memory access completes this cycle
- irwrite  out  1  instruction-register load enable
- nextpc  out  1  PC update request (non-branch)
- branch  out  1  branch PC-write request (ungated)
- regw  out  1  register-file write request (ungated)
- memw  out  1  memory write request (ungated)
- adrsrc  out  1  0 = address from PC, 1 = address from ALU result
- resultsrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alusrca  out  2  00 = Rn, 01 = PC, 10 = ALUOut
- alusrcb  out  2  00 = Rm, 01 = ExtImm, 10 = constant 4
- aluop  out  1  1 = ALU decoder uses funct; 0 = force ADD
- state_o  out  STATE_W  current state encoding, for debug
- trap  out  1  illegal-op indication (see Optional Feature)

Behaviour:
- Moore FSM. The state register is the only storage. It updates on posedge clk and is reset asynchronously to FETCH.
- All outputs are decoded combinationally from the state. The only input term in any output is mem_ready, where stated below.
- Any output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10, TRAP=11. state_o shows this encoding.
- Outputs in FETCH: adrsrc=0, alusrca=01, alusrcb=10, aluop=0, resultsrc=10, irwrite=mem_ready, nextpc=mem_ready.
- Outputs in DECODE: alusrca=01, alusrcb=10, resultsrc=10 (reads PC+8).
- Outputs in MEMADR: alusrca=00, alusrcb=01, aluop=0.
- Outputs in MEMRD: adrsrc=1, resultsrc=00.
- Outputs in MEMWB: resultsrc=01, regw=1.
- Outputs in MEMWR: adrsrc=1, resultsrc=00, memw=1. memw is held for the whole wait.
- Outputs in EXECUTER: alusrca=00, alusrcb=00, aluop=1.
- Outputs in EXECUTEI: alusrca=00, alusrcb=01, aluop=1.
- Outputs in ALUWB: resultsrc=00, regw=1.
- Outputs in BRANCH: alusrca=10, alusrcb=01, aluop=0, resultsrc=10, branch=1.
- Outputs in UNKNOWN and TRAP: all control outputs 0.
- Transitions from FETCH, MEMRD and MEMWR: stay while mem_ready=0. On mem_ready=1, FETCH→DECODE, MEMRD→MEMWB, MEMWR→FETCH.
- Transitions from DECODE:
  - op=00 and funct[5]=0 → EXECUTER
  - op=00 and funct[5]=1 → EXECUTEI
  - op=01 → MEMADR
  - op=10 → BRANCH
  - op=11 → UNKNOWN
- Transitions from MEMADR: funct[0]=1 → MEMRD; funct[0]=0 → MEMWR.
- Unconditional transitions:
  - EXECUTER/EXECUTEI→ALUWB
  - ALUWB→FETCH
  - MEMWB→FETCH
  - BRANCH→FETCH
- UNKNOWN: see Optional Feature.
- Any unused state encoding (12–15) → FETCH on the next clock; all outputs 0 while in it.
- Latencies with zero-wait memory:
  - data-processing: 4 cycles
  - LDR: 5 cycles
  - STR: 4 cycles
  - B: 3 cycles
- Each added mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Reset asserted mid-instruction: the state goes to FETCH immediately (asynchronous). An in-progress memw drops the same instant. No strobe is asserted while reset=1, except the mem_ready-gated FETCH strobes.
- op and funct are sampled only in DECODE and MEMADR. Changes to them in other states have no effect.

Optional Feature:
- Macro: ARM_MAINFSM_TRAP_EN.
- Defined:
  - UNKNOWN→TRAP.
  - TRAP is absorbing: it is left only by reset.
  - trap=1 in TRAP only.
- Undefined:
  - UNKNOWN→FETCH, so the illegal instruction executes as a no-op.
  - The PC still advances, because nextpc fired in FETCH.
  - The TRAP state is unreachable.
  - trap is tied to 0.

Test Plan:
- Reset, then release with mem_ready=1 → state_o=0 with irwrite=nextpc=1 in the first cycle; DECODE in the next cycle.
- ADD reg (op=00, funct=001000), mem_ready=1 → states 0,1,6,8,0; regw=1 only in the ALUWB cycle; aluop=1 in EXECUTER.
- LDR (op=01, funct=011001) with mem_ready held low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; adrsrc=1 on all three MEMRD cycles; regw=1 in MEMWB only.
- STR (op=01, funct=011000), mem_ready=0 for 1 cycle → memw=1 for 2 consecutive cycles, then FETCH; regw never 1.
- B (op=10) → states 0,1,9,0; branch=1 exactly one cycle with alusrca=10, alusrcb=01.
- op=11 → with ARM_MAINFSM_TRAP_EN: state goes to 11, trap stays 1 until reset, and reset asserted mid-TRAP returns to 0. Without the macro: 10 then 0, trap=0.

Source files
------------

// File: rtl/arm_mainfsm.sv
// Main control FSM for the multicycle ARM datapath, with memory-ready stalls.
// Define ARM_MAINFSM_TRAP_EN to make undefined instructions lock the FSM in TRAP.
module arm_mainfsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         op,
   input  logic [5:0]         funct,
   input  logic               mem_ready,
   output logic               irwrite,
   output logic               nextpc,
   output logic               branch,
   output logic               regw,
   output logic               memw,
   output logic               adrsrc,
   output logic [1:0]         resultsrc,
   output logic [1:0]         alusrca,
   output logic [1:0]         alusrcb,
   output logic               aluop,
   output logic [STATE_W-1:0] state_o,
   output logic               trap
);

   localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
   localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
   localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
   localparam logic [STATE_W-1:0] S_MEMRD    = STATE_W'(3);
   localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
   localparam logic [STATE_W-1:0] S_MEMWR    = STATE_W'(5);
   localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(6);
   localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(7);
   localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
   localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
   localparam logic [STATE_W-1:0] S_UNKNOWN  = STATE_W'(10);
   localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(11);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;

   // Only the I and L/S bits of funct steer the sequence.
   logic funct_unused;
   assign funct_unused = ^funct[4:1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_UNKNOWN;
            endcase
         end
         S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
`ifdef ARM_MAINFSM_TRAP_EN
         S_UNKNOWN:  state_d = S_TRAP;
         S_TRAP:     state_d = S_TRAP;
`else
         // Undefined instruction retires as a no-op; the PC already advanced in FETCH.
         S_UNKNOWN:  state_d = S_FETCH;
         S_TRAP:     state_d = S_FETCH;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      irwrite   = 1'b0;
      nextpc    = 1'b0;
      branch    = 1'b0;
      regw      = 1'b0;
      memw      = 1'b0;
      adrsrc    = 1'b0;
      resultsrc = 2'b00;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      aluop     = 1'b0;
      trap      = 1'b0;
      case (state_q)
         S_FETCH: begin
            irwrite   = mem_ready;
            nextpc    = mem_ready;
            resultsrc = 2'b10;
            alusrca   = 2'b01;
            alusrcb   = 2'b10;
         end
         S_DECODE: begin
            resultsrc = 2'b10;
            alusrca   = 2'b01;
            alusrcb   = 2'b10;
         end
         S_MEMADR:   alusrcb = 2'b01;
         S_MEMRD:    adrsrc  = 1'b1;
         S_MEMWB: begin
            resultsrc = 2'b01;
            regw      = 1'b1;
         end
         S_MEMWR: begin
            adrsrc = 1'b1;
            memw   = 1'b1;
         end
         S_EXECUTER: aluop = 1'b1;
         S_EXECUTEI: begin
            alusrcb = 2'b01;
            aluop   = 1'b1;
         end
         S_ALUWB:    regw = 1'b1;
         S_BRANCH: begin
            alusrca   = 2'b10;
            alusrcb   = 2'b01;
            resultsrc = 2'b10;
            branch    = 1'b1;
         end
`ifdef ARM_MAINFSM_TRAP_EN
         S_TRAP:     trap = 1'b1;
`endif
         default: ;
      endcase
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_arm_mainfsm.sv
// Randomized bench for arm_mainfsm: per-instruction state traces built from the
// instruction-class rules, with control outputs looked up per state.
module tb_arm_mainfsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] op;
   logic [5:0] funct;
   logic       mem_ready;
   logic       irwrite, nextpc, branch, regw, memw, adrsrc, aluop, trap;
   logic [1:0] resultsrc, alusrca, alusrcb;
   logic [3:0] state_o;
   logic [13:0] ctrl;

   int checks = 0;
   int errors = 0;

   arm_mainfsm #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
      .irwrite(irwrite), .nextpc(nextpc), .branch(branch), .regw(regw), .memw(memw),
      .adrsrc(adrsrc), .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
      .aluop(aluop), .state_o(state_o), .trap(trap)
   );

   always #5 clk = ~clk;

   assign ctrl = {irwrite, nextpc, branch, regw, memw, adrsrc, resultsrc,
                  alusrca, alusrcb, aluop, trap};

`ifdef ARM_MAINFSM_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   // Control word each state is documented to present.
   function automatic logic [13:0] exp_ctrl(input int s, input logic mr);
      logic irw, npc, br, rw, mw, adr, al, tr;
      logic [1:0] rs, a, b;
      irw = 0; npc = 0; br = 0; rw = 0; mw = 0; adr = 0; al = 0; tr = 0;
      rs = 2'b00; a = 2'b00; b = 2'b00;
      case (s)
         0:  begin irw = mr; npc = mr; rs = 2'b10; a = 2'b01; b = 2'b10; end
         1:  begin rs = 2'b10; a = 2'b01; b = 2'b10; end
         2:  begin a = 2'b00; b = 2'b01; end
         3:  adr = 1;
         4:  begin rs = 2'b01; rw = 1; end
         5:  begin adr = 1; mw = 1; end
         6:  al = 1;
         7:  begin b = 2'b01; al = 1; end
         8:  rw = 1;
         9:  begin a = 2'b10; b = 2'b01; rs = 2'b10; br = 1; end
         11: tr = TRAP_EN;
         default: ;
      endcase
      return {irw, npc, br, rw, mw, adr, rs, a, b, al, tr};
   endfunction

   // Entered and left just after a rising edge with the DUT in FETCH.
   task automatic run_instr(input logic [1:0] op_i, input logic [5:0] f_i,
                            input int wf, input int wm, input string nm);
      int st[$];
      bit mr[$];
      int expected_len;
      for (int i = 0; i < wf; i++) begin st.push_back(0); mr.push_back(0); end
      st.push_back(0); mr.push_back(1);
      st.push_back(1); mr.push_back(0);
      case (op_i)
         2'b00: begin
            st.push_back(f_i[5] ? 7 : 6); mr.push_back(0);
            st.push_back(8); mr.push_back(0);
         end
         2'b01: begin
            st.push_back(2); mr.push_back(0);
            if (f_i[0]) begin
               for (int i = 0; i < wm; i++) begin st.push_back(3); mr.push_back(0); end
               st.push_back(3); mr.push_back(1);
               st.push_back(4); mr.push_back(0);
            end else begin
               for (int i = 0; i < wm; i++) begin st.push_back(5); mr.push_back(0); end
               st.push_back(5); mr.push_back(1);
            end
         end
         2'b10: begin st.push_back(9); mr.push_back(0); end
         default: begin
            st.push_back(10); mr.push_back(0);
            if (TRAP_EN) begin
               for (int i = 0; i < 3; i++) begin st.push_back(11); mr.push_back(0); end
            end
         end
      endcase
      for (int i = 0; i < st.size(); i++) begin
         if (st[i] == 1 || st[i] == 2) begin
            op = op_i; funct = f_i;
         end else begin
            op = 2'($urandom); funct = 6'($urandom);
         end
         if (st[i] == 0 || st[i] == 3 || st[i] == 5) mem_ready = mr[i];
         else mem_ready = 1'($urandom);
         #4;
         checks++;
         if (state_o !== 4'(st[i])) begin
            errors++;
            $display("FAIL %s state cyc=%0d got=%0d exp=%0d", nm, i, state_o, st[i]);
         end
         checks++;
         if (ctrl !== exp_ctrl(st[i], mem_ready)) begin
            errors++;
            $display("FAIL %s ctrl cyc=%0d state=%0d got=%b exp=%b", nm, i, st[i],
                     ctrl, exp_ctrl(st[i], mem_ready));
         end
         @(posedge clk); #1;
      end
      if (op_i == 2'b11 && TRAP_EN) begin
         #3 reset = 1'b1;
         #1;
         checks++;
         if (state_o !== 4'd0 || trap !== 1'b0) begin
            errors++;
            $display("FAIL %s trap_reset got state=%0d trap=%b exp state=0 trap=0", nm, state_o, trap);
         end
         @(posedge clk); #1 reset = 1'b0;
         $display("instr %s op=%0d funct=%b wf=%0d -> trapped, reset", nm, op_i, f_i, wf);
      end else begin
         if (op_i == 2'b00) expected_len = 4 + wf;
         else if (op_i == 2'b01) expected_len = (f_i[0] ? 5 : 4) + wf + wm;
         else expected_len = 3 + wf;
         mem_ready = 1'b0;
         #1;
         checks++;
         if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL %s latency: after %0d cycles state=%0d exp=0", nm, expected_len, state_o);
         end
         $display("instr %s op=%0d funct=%b wf=%0d wm=%0d cycles=%0d", nm, op_i, f_i, wf, wm, expected_len);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_ready = 1'b1; op = 2'b00; funct = 6'd0;
      #12;
      checks++;
      if (state_o !== 4'd0 || irwrite !== 1'b1 || nextpc !== 1'b1 || regw !== 1'b0 || memw !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold got state=%0d irw=%b npc=%b regw=%b memw=%b exp 0 1 1 0 0",
                  state_o, irwrite, nextpc, regw, memw);
      end
      @(posedge clk); #1 reset = 1'b0;
      #4;
      checks++;
      if (state_o !== 4'd0 || irwrite !== 1'b1 || nextpc !== 1'b1) begin
         errors++;
         $display("FAIL reset_first got state=%0d irw=%b npc=%b exp 0 1 1", state_o, irwrite, nextpc);
      end
      @(posedge clk); #1;
      checks++;
      if (state_o !== 4'd1) begin
         errors++;
         $display("FAIL reset_decode got state=%0d exp=1", state_o);
      end
      $display("reset released -> fetch then decode");
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
   endtask

   task automatic test_directed();
      run_instr(2'b00, 6'b001000, 0, 0, "add");
      run_instr(2'b00, 6'b101000, 1, 0, "addi");
      run_instr(2'b01, 6'b011001, 0, 2, "ldr");
      run_instr(2'b01, 6'b011000, 0, 1, "str");
      run_instr(2'b01, 6'b011001, 0, 0, "ldr0");
      run_instr(2'b10, 6'b000000, 0, 0, "b");
      run_instr(2'b11, 6'b000000, 0, 0, "undef");
   endtask

   task automatic test_async_reset();
      op = 2'b01; funct = 6'b011000; mem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      #3;
      checks++;
      if (state_o !== 4'd5 || memw !== 1'b1) begin
         errors++;
         $display("FAIL async_pre got state=%0d memw=%b exp 5 1", state_o, memw);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (state_o !== 4'd0 || memw !== 1'b0 || irwrite !== 1'b0 || regw !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got state=%0d memw=%b irw=%b regw=%b exp 0 0 0 0",
                  state_o, memw, irwrite, regw);
      end
      mem_ready = 1'b1;
      #1;
      checks++;
      if (irwrite !== 1'b1 || nextpc !== 1'b1 || branch !== 1'b0 || memw !== 1'b0) begin
         errors++;
         $display("FAIL async_strobes got irw=%b npc=%b br=%b memw=%b exp 1 1 0 0",
                  irwrite, nextpc, branch, memw);
      end
      @(posedge clk); #1;
      checks++;
      if (state_o !== 4'd0) begin
         errors++;
         $display("FAIL async_hold got state=%0d exp=0", state_o);
      end
      reset = 1'b0;
      $display("async reset during MEMWR -> fetch, memw dropped");
   endtask

   task automatic test_random();
      logic [1:0] rop;
      logic [5:0] rf;
      for (int n = 0; n < 40; n++) begin
         rop = TRAP_EN ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
         rf  = 6'($urandom);
         run_instr(rop, rf, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_async_reset();
      test_random();
      run_instr(2'b00, 6'b000000, 0, 0, "tail");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
